onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Shares the single-port 1000 x 32 on-chip RAM between two Avalon-MM masters: m0 (Nios II data master) and m1 (DMA/peripheral master).
- Round-robin arbitration, at most one RAM access per cycle.
- Drives the RAM's address/byteenable/chipselect/write/writedata/clken pins and returns read data with readdatavalid, one cycle after grant.
- Sits between the interconnect and the on-chip memory instance in mynios2.

Parameters:
- ADDR_W, 10, word-address width of RAM and of both master ports.
- DATA_W, 32, data width.
- BE_W, 4, byteenable width (DATA_W/8).
- NUM_WORDS, 1000, implemented RAM depth; addresses >= NUM_WORDS are out of range.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  BE_W  master 0 byte lanes.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_*  same set as m0, for master 1.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  BE_W  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_clken  out  1  to RAM clken; tied 1 out of reset.
- ram_readdata  in  DATA_W  RAM q, valid the cycle after the address edge.

Behaviour:
- Request: mX_req = mX_read | mX_write. Read and write asserted together is illegal; treat as write and flag in assertion.
- Grant (combinational, same cycle):
  - Only one master requesting: that master wins.
  - Both requesting: the master not granted last wins.
  - prio register: 0 favours m0. Resets to 0 and updates on every grant to point away from the winner.
- Waitrequest: mX_waitrequest = mX_req & ~grantX. It is 0 when idle, so there is no dead cycle; zero-wait access on grant.
- Granted master's address, byteenable and writedata are muxed to the ram_* pins in the same cycle.
- ram_chipselect = any grant. ram_write = granted write.
- No grant: ram_byteenable = 0, ram_write = 0, ram_chipselect = 0.
- Out of range (address >= NUM_WORDS):
  - Still granted (no stall).
  - Write: ram_write and ram_chipselect forced 0.
  - Read: returns all-zero data with readdatavalid.
- Read pipeline, 1-stage register:
  - rd_valid, rd_owner and rd_oor capture at the grant edge.
  - Next cycle: mX_readdatavalid = rd_valid & (rd_owner==X).
  - mX_readdata = rd_oor ? 0 : ram_readdata, driven to both masters; only valid when the owner's readdatavalid is high.
  - Back-to-back reads from alternating masters sustain 1 read/cycle.
  - Read latency is exactly 1 cycle after the accepted (waitrequest-low) cycle.
- A write may be granted in the cycle a previous read's data returns; the pipeline is unaffected.
- Reset (async, reset_n low):
  - prio=0, rd_valid=0, rd_owner=0, rd_oor=0.
  - Both readdatavalid=0.
  - ram_chipselect/ram_write follow requests combinationally but are forced 0 while reset_n is low.
  - ram_clken=0 while reset_n is low, 1 after.
- Reset mid-read: the pending readdatavalid is dropped, never asserted after deassertion. Masters must reissue.
- Fairness: neither master waits more than 1 cycle under continuous contention.

Test Plan:
- Reset, then m0 reads addr 5 (preloaded 0xDEADBEEF) -> m0_waitrequest=0 that cycle; next cycle m0_readdatavalid=1, m0_readdata=0xDEADBEEF; m1_readdatavalid=0.
- m0 and m1 both read continuously (addr 1, addr 2) from reset -> grants m0,m1,m0,m1; each waitrequest high in alternate cycles; one readdatavalid per cycle, owner alternating.
- m1 writes addr 10, byteenable 4'b0011, data 0x12345678 over 0xFFFFFFFF, then m1 reads 10 -> readdata 0xFFFF5678.
- m0 writes addr 1000 data 0xA5A5A5A5, then reads 1000 -> ram_write never asserted; readdatavalid=1 with readdata 0x00000000.
- m0 read granted, reset_n pulsed low before the next edge -> no readdatavalid after release; prio=0, so a simultaneous request next cycle grants m0.
- m0 write and m1 read simultaneous, then m1 write and m0 read -> second cycle grants m0; all data correct; ram_chipselect high both cycles.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Shares one single-port on-chip RAM (NUM_WORDS x DATA_W, 1-cycle registered
// read) between two Avalon-MM masters: m0 (Nios II data master) and m1
// (DMA / peripheral master). One RAM access per cycle, round-robin on
// contention, zero-wait acceptance for the granted master.
//
// Ports
//   clk, reset_n              system clock (rising edge), async active-low reset
//   m0_* / m1_*               Avalon-MM slave ports, one per master:
//     address, byteenable     word address / byte lanes
//     read, write, writedata  request strobes and write data
//     waitrequest             stall (request present but not granted)
//     readdata, readdatavalid read return, one cycle after acceptance
//   ram_address/byteenable/chipselect/write/writedata/clken
//                             pins to the RAM instance
//   ram_readdata              RAM q, valid the cycle after the address edge
//
// Out-of-range accesses (address >= NUM_WORDS) are accepted without stall:
// writes never reach the RAM, reads return all-zero data.
// -----------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int NUM_WORDS = 1000
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);

  // One extra bit so the limit is representable even when NUM_WORDS == 2**ADDR_W.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(NUM_WORDS);

  logic m0_req;
  logic m1_req;
  logic grant0;
  logic grant1;
  logic any_grant;

  // prio_q = 0 favours m0 on contention, 1 favours m1.
  logic prio_q;
  logic prio_d;

  // Read return pipeline: one entry, captured on the accepting edge.
  logic rd_valid_q;
  logic rd_valid_d;
  logic rd_owner_q;
  logic rd_owner_d;
  logic rd_oor_q;
  logic rd_oor_d;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_oor;
  logic [DATA_W-1:0] rdata;

  // Read and write together is treated as a write (write wins in sel_write).
  assign m0_req = m0_read | m0_write;
  assign m1_req = m1_read | m1_write;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (m0_req && m1_req) begin
      if (prio_q) grant1 = 1'b1;
      else        grant0 = 1'b1;
    end else if (m0_req) begin
      grant0 = 1'b1;
    end else if (m1_req) begin
      grant1 = 1'b1;
    end
  end

  assign any_grant = grant0 | grant1;

  assign m0_waitrequest = m0_req & ~grant0;
  assign m1_waitrequest = m1_req & ~grant1;

  always_comb begin
    sel_addr  = m0_address;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    sel_write = m0_write;
    if (grant1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = m1_write;
    end
  end

  assign sel_oor = ({1'b0, sel_addr} >= ADDR_LIMIT);

  // Out-of-range writes are swallowed entirely; out-of-range reads still
  // select the RAM but their data is replaced by zero on the return path.
  assign ram_address    = sel_addr;
  assign ram_writedata  = sel_wdata;
  assign ram_byteenable = any_grant ? sel_be : '0;
  assign ram_chipselect = reset_n & any_grant & ~(sel_write & sel_oor);
  assign ram_write      = reset_n & any_grant & sel_write & ~sel_oor;
  assign ram_clken      = reset_n;

  always_comb begin
    prio_d     = prio_q;
    rd_valid_d = 1'b0;
    rd_owner_d = rd_owner_q;
    rd_oor_d   = rd_oor_q;
    if (any_grant) begin
      // Point away from the winner so the other master wins next contention.
      prio_d     = grant0;
      rd_valid_d = ~sel_write;
      rd_owner_d = grant1;
      rd_oor_d   = sel_oor;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  // Data bus is shared; only the owner's readdatavalid qualifies it.
  assign rdata            = rd_oor_q ? '0 : ram_readdata;
  assign m0_readdata      = rdata;
  assign m1_readdata      = rdata;
  assign m0_readdatavalid = rd_valid_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_valid_q &  rd_owner_q;

  // Simultaneous read and write from one master is a protocol violation.
  a_m0_rw_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
                                       !(m0_read && m0_write));
  a_m1_rw_exclusive : assert property (@(posedge clk) disable iff (!reset_n)
                                       !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [9:0]  m0_address = '0;
  logic [3:0]  m0_byteenable = '0;
  logic        m0_read = 1'b0;
  logic        m0_write = 1'b0;
  logic [31:0] m0_writedata = '0;
  logic        m0_waitrequest;
  logic [31:0] m0_readdata;
  logic        m0_readdatavalid;

  logic [9:0]  m1_address = '0;
  logic [3:0]  m1_byteenable = '0;
  logic        m1_read = 1'b0;
  logic        m1_write = 1'b0;
  logic [31:0] m1_writedata = '0;
  logic        m1_waitrequest;
  logic [31:0] m1_readdata;
  logic        m1_readdatavalid;

  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic [31:0] ram_writedata;
  logic        ram_clken;
  logic [31:0] ram_readdata = '0;

  int errors = 0;
  int checks = 0;

  onchip_mem_arbiter #(
    .ADDR_W(10), .DATA_W(32), .BE_W(4), .NUM_WORDS(1000)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    if (i == 5)  return 32'hDEADBEEF;
    if (i == 10) return 32'hFFFFFFFF;
    return 32'(i) * 32'h9E3779B1 + 32'h1234;
  endfunction

  // RAM instance model: registered read, byte-lane writes, gated by clken.
  logic [31:0] ram_mem [0:1023];
  bit          preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_val(i);
      preloaded <= 1'b1;
    end else if (ram_clken && ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= (ram_address < 10'd1000) ? ram_mem[ram_address] : 32'hBAD0BAD0;
      end
    end
  end

  // Reference model state: architectural memory contents, who won last,
  // and the read expected back on the next cycle.
  logic [31:0] exp_mem [0:1023];
  int          last_win;
  bit          pend_v;
  int          pend_owner;
  logic [31:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    last_win = 1;  // so m0 is favoured first
    pend_v   = 1'b0;
  endtask

  // Inputs are already applied; check this cycle's outputs at the falling
  // edge, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    bit          r0, r1, wr, oor;
    int          win;
    logic [9:0]  a;
    logic [3:0]  be;
    logic [31:0] wd;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (r0 && r1)  win = (last_win == 0) ? 1 : 0;
    else if (r0)   win = 0;
    else if (r1)   win = 1;
    else           win = -1;
    wr = 1'b0; oor = 1'b0; a = '0; be = '0; wd = '0;
    if (win == 0) begin wr = m0_write; a = m0_address; be = m0_byteenable; wd = m0_writedata; end
    if (win == 1) begin wr = m1_write; a = m1_address; be = m1_byteenable; wd = m1_writedata; end
    oor = (int'(a) >= 1000);

    @(negedge clk);
    chk({tag, " wait0"}, 32'(m0_waitrequest), 32'(r0 && win != 0));
    chk({tag, " wait1"}, 32'(m1_waitrequest), 32'(r1 && win != 1));
    chk({tag, " rdv0"}, 32'(m0_readdatavalid), 32'(pend_v && pend_owner == 0));
    chk({tag, " rdv1"}, 32'(m1_readdatavalid), 32'(pend_v && pend_owner == 1));
    if (pend_v)
      chk({tag, " rdata"}, (pend_owner == 0) ? m0_readdata : m1_readdata, pend_data);
    if (win >= 0) begin
      chk({tag, " cs"}, 32'(ram_chipselect), 32'(!(wr && oor)));
      chk({tag, " we"}, 32'(ram_write), 32'(wr && !oor));
      chk({tag, " be"}, 32'(ram_byteenable), 32'(be));
      chk({tag, " addr"}, 32'(ram_address), 32'(a));
      if (wr && !oor) chk({tag, " wdata"}, ram_writedata, wd);
    end else begin
      chk({tag, " idle cs"}, 32'(ram_chipselect), 32'd0);
      chk({tag, " idle we"}, 32'(ram_write), 32'd0);
      chk({tag, " idle be"}, 32'(ram_byteenable), 32'd0);
    end

    @(posedge clk);
    pend_v = 1'b0;
    if (win >= 0) begin
      last_win = win;
      if (wr) begin
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (be[b]) exp_mem[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        pend_v     = 1'b1;
        pend_owner = win;
        pend_data  = oor ? 32'h0 : exp_mem[a];
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic set_m0(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic set_m1(input bit rd, input bit wr, input logic [9:0] a,
                        input logic [3:0] be, input logic [31:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst clken", 32'(ram_clken), 32'd0);
    chk("rst rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("rst rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("rst cs", 32'(ram_chipselect), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post rst clken", 32'(ram_clken), 32'd1);
  endtask

  initial begin
    int op0, op1;
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_val(i);
    model_reset();

    // Reset, then single read of preloaded word 5.
    do_reset();
    set_m0(1, 0, 10'd5, 4'hF, 0);
    cycle("t1 rd5");
    idle_inputs();
    chk("t1 rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("t1 rdv1", 32'(m1_readdatavalid), 32'd0);
    chk("t1 rdata", m0_readdata, 32'hDEADBEEF);
    cycle("t1 idle");

    // Continuous contention from reset: m0,m1,m0,m1...
    do_reset();
    set_m0(1, 0, 10'd1, 4'hF, 0);
    set_m1(1, 0, 10'd2, 4'hF, 0);
    for (int i = 0; i < 6; i++) cycle("t2 contend");
    idle_inputs();
    cycle("t2 drain");

    // m1 partial write over 0xFFFFFFFF then read back.
    set_m1(0, 1, 10'd10, 4'b0011, 32'h12345678);
    cycle("t3 wr10");
    set_m1(1, 0, 10'd10, 4'hF, 0);
    cycle("t3 rd10");
    idle_inputs();
    chk("t3 rdv1", 32'(m1_readdatavalid), 32'd1);
    chk("t3 rdata", m1_readdata, 32'hFFFF5678);
    cycle("t3 idle");

    // Out-of-range write then read at 1000.
    set_m0(0, 1, 10'd1000, 4'hF, 32'hA5A5A5A5);
    cycle("t4 wr1000");
    set_m0(1, 0, 10'd1000, 4'hF, 0);
    cycle("t4 rd1000");
    idle_inputs();
    chk("t4 rdv0", 32'(m0_readdatavalid), 32'd1);
    chk("t4 rdata", m0_readdata, 32'h0);
    cycle("t4 idle");

    // Reset pulse while a read result is pending.
    set_m0(1, 0, 10'd5, 4'hF, 0);
    set_m1(1, 0, 10'd2, 4'hF, 0);
    cycle("t5 contend");
    set_m0(1, 0, 10'd5, 4'hF, 0);
    set_m1(0, 0, 10'd2, 4'hF, 0);
    cycle("t5 rd");
    idle_inputs();
    m1_read = 1;
    #1 reset_n = 1'b0;
    #1;
    chk("t5 rst rdv0", 32'(m0_readdatavalid), 32'd0);
    chk("t5 rst cs", 32'(ram_chipselect), 32'd0);
    chk("t5 rst clken", 32'(ram_clken), 32'd0);
    #1 reset_n = 1'b1;
    model_reset();
    set_m0(1, 0, 10'd1, 4'hF, 0);
    set_m1(1, 0, 10'd2, 4'hF, 0);
    cycle("t5 after");
    chk("t5 prio m0 wins", 32'(m0_readdatavalid), 32'd1);
    idle_inputs();
    cycle("t5 idle");

    // Mixed write/read in consecutive contended cycles.
    set_m0(0, 1, 10'd20, 4'hF, 32'hCAFEF00D);
    set_m1(1, 0, 10'd21, 4'hF, 0);
    cycle("t6 c1");
    set_m0(1, 0, 10'd21, 4'hF, 0);
    set_m1(0, 1, 10'd20, 4'b1100, 32'h99887766);
    cycle("t6 c2");
    set_m1(0, 0, 10'd20, 4'h0, 0);
    set_m0(0, 1, 10'd20, 4'hF, 32'hCAFEF00D);
    cycle("t6 c3");
    set_m0(1, 0, 10'd20, 4'hF, 0);
    cycle("t6 c4");
    idle_inputs();
    cycle("t6 idle");

    // Random traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      op0 = $urandom_range(0, 3);
      op1 = $urandom_range(0, 3);
      set_m0(op0 == 1 || op0 == 2, op0 == 3,
             ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom);
      set_m1(op1 == 1 || op1 == 2, op1 == 3,
             ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), $urandom);
      cycle("rand");
    end
    idle_inputs();
    cycle("final drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
